// File: rtl/prog_ctr.sv
// prog_ctr: PC register with hold/absolute jump/increment; define BRANCH_REL_EN for the flag-gated relative branch
module prog_ctr #(
  parameter int PC_W = 10,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchAbsEn,
  input  logic            ALU_flag,
`ifdef BRANCH_REL_EN
  input  logic            BranchRelEn,
`endif
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr
);
  logic [PC_W-1:0] nextPc;
`ifdef BRANCH_REL_EN
  always_comb nextPc = !Start ? ProgCtr :
                       BranchAbsEn ? Target :
                       (BranchRelEn && ALU_flag) ? ProgCtr + Target :
                       ProgCtr + PC_W'(1);
`else
  logic unusedFlag;
  assign unusedFlag = ALU_flag;
  always_comb nextPc = !Start ? ProgCtr : BranchAbsEn ? Target : ProgCtr + PC_W'(1);
`endif
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) ProgCtr <= RESET_VEC;
    else ProgCtr <= nextPc;
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: scoreboard bench for prog_ctr; exercises BranchRelEn when BRANCH_REL_EN is defined
module tb_prog_ctr;
  logic Clk = 0, Reset = 0, Start = 0, BranchAbsEn = 0, ALU_flag = 0, BranchRelEn = 0;
  logic [9:0] Target = '0;
  logic [9:0] ProgCtr;
  logic [9:0] expQ[$], obsQ[$];
  int vectors = 0, miscompares = 0;

  prog_ctr #(.PC_W(10), .RESET_VEC(10'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchAbsEn(BranchAbsEn), .ALU_flag(ALU_flag),
`ifdef BRANCH_REL_EN
    .BranchRelEn(BranchRelEn),
`endif
    .Target(Target), .ProgCtr(ProgCtr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    obsQ.push_back(ProgCtr);
  endtask

  task automatic drive(input logic s, input logic abs, input logic rel, input logic flag,
                       input logic [9:0] tgt, input logic [9:0] e);
    Start = s; BranchAbsEn = abs; BranchRelEn = rel; ALU_flag = flag; Target = tgt;
    expQ.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    Reset = 0;
    drive(0, 0, 0, 0, 0, 10'd0);
    Reset = 1;
    drive(1, 1, 0, 0, 10'd300, 10'd300);
    #2;
    Reset = 0;
    #1;
    expQ.push_back(10'd0);
    obsQ.push_back(ProgCtr);
    Reset = 1;
    drive(0, 0, 0, 0, 0, 10'd0);
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_hold();
    drive(0, 1, 0, 0, 10'd10, 10'd0);
    drive(0, 0, 0, 1, 10'd10, 10'd0);
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL hold: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_abs_jump();
    drive(1, 1, 0, 0, 10'd10, 10'd10);
    drive(1, 0, 0, 0, 10'd10, 10'd11);
    drive(1, 0, 0, 1, 10'd99, 10'd12);
    drive(1, 1, 0, 1, 10'd500, 10'd500);
    drive(1, 1, 0, 0, 10'd1023, 10'd1023);
    drive(1, 0, 0, 0, 10'd0, 10'd0);
    drive(1, 0, 0, 0, 10'd0, 10'd1);
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL abs_jump/wrap: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_rel_branch();
    drive(1, 1, 0, 0, 10'd20, 10'd20);
`ifdef BRANCH_REL_EN
    drive(1, 0, 1, 1, 10'h3FC, 10'd16);
    drive(1, 1, 0, 0, 10'd20, 10'd20);
    drive(1, 0, 1, 0, 10'h3FC, 10'd21);
    drive(1, 1, 1, 1, 10'd5, 10'd5);
    drive(1, 0, 1, 1, 10'h3F8, 10'd1021);
    drive(1, 0, 1, 1, 10'd7, 10'd4);
    drive(0, 0, 1, 1, 10'd7, 10'd4);
`else
    drive(1, 0, 1, 1, 10'h3FC, 10'd21);
    drive(1, 0, 0, 1, 10'd7, 10'd22);
`endif
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL rel_branch: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_start_toggle();
    drive(1, 1, 0, 0, 10'd10, 10'd10);
    for (int i = 0; i < 3; i++) drive(0, i[0], 0, 1, 10'd77, 10'd10);
    drive(1, 0, 0, 0, 10'd0, 10'd11);
    drive(0, 0, 0, 0, 10'd0, 10'd11);
    drive(1, 0, 0, 0, 10'd0, 10'd12);
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL start_toggle: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1, 0, 0, 0, 10'd0, 10'd13);
    Start = 1; BranchAbsEn = 1; Target = 10'd7;
    #2;
    Reset = 0;
    #1;
    expQ.push_back(10'd0);
    obsQ.push_back(ProgCtr);
    tick();
    expQ.push_back(10'd0);
    Reset = 1;
    drive(1, 0, 0, 0, 10'd0, 10'd1);
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mid_reset: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] m;
    logic s, abs, rel, flag;
    logic [9:0] tgt;
    drive(1, 1, 0, 0, 10'd1000, 10'd1000);
    m = 10'd1000;
    for (int i = 0; i < 80; i++) begin
      s = ($urandom_range(0, 7) != 0);
      abs = ($urandom_range(0, 5) == 0);
      rel = $urandom_range(0, 1) == 1;
      flag = $urandom_range(0, 1) == 1;
      tgt = 10'($urandom_range(0, 1023));
`ifdef BRANCH_REL_EN
      if (!s) m = m;
      else if (abs) m = tgt;
      else if (rel && flag) m = m + tgt;
      else m = m + 10'd1;
`else
      if (!s) m = m;
      else if (abs) m = tgt;
      else m = m + 10'd1;
`endif
      drive(s, abs, rel, flag, tgt, m);
    end
    while (expQ.size() > 0) begin
      automatic logic [9:0] e = expQ.pop_front();
      automatic logic [9:0] g = obsQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL back_to_back: ProgCtr=%0d expected %0d", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_abs_jump();
    test_rel_branch();
    test_start_toggle();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
- Program counter for the basic single-cycle processor.
- Holds the instruction-memory address of the current instruction and advances it once per clock.
- Next-address sources: sequential increment, unconditional absolute jump, and (optional) flag-conditional relative branch.
- Execution is gated by a Start run-enable from the top-level controller.

Parameters:
PC_W, 10, width of the program counter and of Target, in bits.
RESET_VEC, 0, value loaded into the counter on reset (PC_W bits).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset; 0 forces ProgCtr to RESET_VEC immediately.
Start  input  1  run enable (level); 1 = counter advances each cycle, 0 = counter holds.
BranchAbsEn  input  1  unconditional absolute jump request from decode.
ALU_flag  input  1  branch condition from ALU; used only by the relative branch.
BranchRelEn  input  1  relative branch request; present only with BRANCH_REL_EN.
Target  input  PC_W  absolute jump address, or signed two's-complement offset for a relative branch.
ProgCtr  output  PC_W  current program counter; registered output, no combinational path from inputs.

Behaviour:
- Single PC_W-bit register drives ProgCtr directly.
- Reset:
  - Reset low: ProgCtr = RESET_VEC asynchronously, regardless of Clk.
  - While Reset is low, the register holds RESET_VEC.
  - Release is synchronised by the normal edge logic: the first update occurs on the first rising Clk edge with Reset high.
- On each rising Clk edge with Reset high, next value by priority:
  1. Start == 0: hold (ProgCtr unchanged). All branch and increment requests are ignored.
  2. BranchAbsEn == 1: ProgCtr <= Target. ALU_flag is ignored, so the jump is unconditional.
  3. BranchRelEn == 1 and ALU_flag == 1 (BRANCH_REL_EN only): ProgCtr <= ProgCtr + Target. Target is treated as a signed PC_W-bit value.
  4. Otherwise: ProgCtr <= ProgCtr + 1.
- Latency: one cycle. A request sampled at edge N is visible on ProgCtr after edge N.
- Arithmetic is modulo 2^PC_W:
  - Increment from all-ones wraps to 0.
  - Relative add wraps in both directions.
  - No overflow flag.
- BranchRelEn == 1 with ALU_flag == 0 (branch not taken): plain increment.
- BranchAbsEn and BranchRelEn both high: the absolute jump wins.
- Start may toggle on any cycle:
  - Dropping Start freezes the PC at its current value.
  - Raising Start resumes from that value on the same edge that samples Start == 1.
- Reset asserted mid-run: PC returns to RESET_VEC immediately. A pending branch in that cycle is discarded.
- No X propagation: all inputs are sampled only at clock edges.

Optional Feature:
BRANCH_REL_EN
- Defined:
  - BranchRelEn port exists.
  - Priority item 3 is implemented.
  - ALU_flag gates the relative branch.
- Undefined:
  - BranchRelEn port is removed.
  - ALU_flag port remains but is ignored.
  - Next-state choice reduces to hold / absolute jump / increment.
  - All other behaviour is identical.

Test Plan:
- Reset low, one Clk pulse with all other inputs 0 -> ProgCtr == 0; also check ProgCtr drops to 0 asynchronously between edges.
- Reset high, Start 0, BranchAbsEn 1, Target 10, one edge -> ProgCtr stays 0.
- Start 1, BranchAbsEn 1, ALU_flag 0, Target 10, one edge -> ProgCtr == 10; then BranchAbsEn 0, one edge -> ProgCtr == 11.
- Load 1023 via absolute jump, then increment -> ProgCtr == 0 (wrap).
- BRANCH_REL_EN, PC = 20:
  - BranchRelEn 1, ALU_flag 1, Target = -4 (0x3FC) -> 16.
  - Same with ALU_flag 0 -> 21.
  - BranchAbsEn 1 and BranchRelEn 1 with Target 5 -> 5.
- Running from 10, drop Start for 3 edges -> stays at value; assert Reset low mid-run -> 0 immediately.
